// File: rtl/eqn_dr_hs_if.sv
// eqn_dr_hs_if
// Groups the three dual-rail links of the equality comparator into one bundle.
//   en       evaluation enable (driven by master)
//   in0/in1  WIDTH-digit dual-rail operands, digit i = bits [2i+1:2i] (driven by master)
//   out_ack  consumer acknowledge for the result digit (driven by master)
//   in0_ack  operand A acknowledge (driven by slave)
//   in1_ack  operand B acknowledge (driven by slave)
//   out      result digit, rail1 = TRUE, rail0 = FALSE (driven by slave)
//   err      sticky illegal-code flag (driven by slave)
// The comparator itself uses the slave modport; producers/consumers use master.
interface eqn_dr_hs_if #(
    parameter int WIDTH = 8
);
    logic                 en;
    logic [2*WIDTH-1:0]   in0;
    logic [2*WIDTH-1:0]   in1;
    logic                 in0_ack;
    logic                 in1_ack;
    logic [1:0]           out;
    logic                 out_ack;
    logic                 err;

    modport master (
        output en, in0, in1, out_ack,
        input  in0_ack, in1_ack, out, err
    );

    modport slave (
        input  en, in0, in1, out_ack,
        output in0_ack, in1_ack, out, err
    );
endinterface

// File: rtl/eqn_dr_hs.sv
// eqn_dr_hs
// WIDTH-digit dual-rail equality comparator with clocked link handshakes.
// Both operands must be complete in the same cycle (with en high) to be accepted;
// the result (in0 == in1) ^ INVERT is registered as one dual-rail digit.
// ENC selects the link protocol:
//   "FP" four-phase return-to-null: IDLE -> DATA -> RTZ -> IDLE
//   "TP" two-phase transition:      IDLE -> WAIT -> IDLE
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   link  eqn_dr_hs_if slave modport (en, in0, in1, out_ack in; in0_ack, in1_ack, out, err out)
// All outputs come straight from registers.
module eqn_dr_hs #(
    parameter int WIDTH  = 8,
    parameter     ENC    = "TP",
    parameter bit INVERT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    eqn_dr_hs_if.slave  link
);
    localparam int RAIL_NUM = 2;
    localparam bit IS_FP    = (ENC == "FP");

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_RTZ,
        S_WAIT
    } state_t;

    state_t                      state_q, state_n;
    logic [1:0]                  out_q, out_n;
    logic                        ack0_q, ack0_n;
    logic                        ack1_q, ack1_n;
    logic                        err_q, err_n;
    logic                        phase_q, phase_n;
    logic [RAIL_NUM*WIDTH-1:0]   prev0_q, prev0_n;
    logic [RAIL_NUM*WIDTH-1:0]   prev1_q, prev1_n;

    // Per-digit symbols: in FP the rails are the code itself, in TP the
    // code is which rails moved since the last accepted token.
    logic [RAIL_NUM*WIDTH-1:0]   sym0, sym1;
    logic [WIDTH-1:0]            ok0, ok1, bad0, bad1, val0, val1;
    logic                        complete0, complete1;
    logic                        illegal0, illegal1;
    logic                        null0, null1;
    logic                        result;

    // Digit decode shared by both encodings: one active rail = valid,
    // both active = illegal, rail1 carries the decoded value.
    always_comb begin
        sym0 = IS_FP ? link.in0 : (link.in0 ^ prev0_q);
        sym1 = IS_FP ? link.in1 : (link.in1 ^ prev1_q);
        ok0  = '0;
        ok1  = '0;
        bad0 = '0;
        bad1 = '0;
        val0 = '0;
        val1 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ok0[i]  = sym0[RAIL_NUM*i] ^ sym0[RAIL_NUM*i+1];
            ok1[i]  = sym1[RAIL_NUM*i] ^ sym1[RAIL_NUM*i+1];
            bad0[i] = sym0[RAIL_NUM*i] & sym0[RAIL_NUM*i+1];
            bad1[i] = sym1[RAIL_NUM*i] & sym1[RAIL_NUM*i+1];
            val0[i] = sym0[RAIL_NUM*i+1];
            val1[i] = sym1[RAIL_NUM*i+1];
        end
        complete0 = &ok0;
        complete1 = &ok1;
        illegal0  = |bad0;
        illegal1  = |bad1;
        null0     = (link.in0 == '0);
        null1     = (link.in1 == '0);
        result    = (val0 == val1) ^ INVERT;
    end

    // Next-state and next-output logic. An illegal digit blocks acceptance
    // (an illegal digit is never "valid", so that operand is incomplete anyway).
    always_comb begin
        state_n = state_q;
        out_n   = out_q;
        ack0_n  = ack0_q;
        ack1_n  = ack1_q;
        err_n   = err_q;
        phase_n = phase_q;
        prev0_n = prev0_q;
        prev1_n = prev1_q;
        case (state_q)
            S_IDLE: begin
                if (illegal0 || illegal1) begin
                    err_n = 1'b1;
                end else if (link.en && complete0 && complete1) begin
                    if (IS_FP) begin
                        out_n   = {result, ~result};
                        ack0_n  = 1'b1;
                        ack1_n  = 1'b1;
                        state_n = S_DATA;
                    end else begin
                        prev0_n = link.in0;
                        prev1_n = link.in1;
                        if (result) begin
                            out_n[1] = ~out_q[1];
                        end else begin
                            out_n[0] = ~out_q[0];
                        end
                        ack0_n  = ~ack0_q;
                        ack1_n  = ~ack1_q;
                        phase_n = ~phase_q;
                        state_n = S_WAIT;
                    end
                end
            end
            S_DATA: begin
                if (link.out_ack) begin
                    out_n   = 2'b00;
                    state_n = S_RTZ;
                end
            end
            // Each operand ack drops independently as soon as that operand nulls.
            S_RTZ: begin
                if (null0) begin
                    ack0_n = 1'b0;
                end
                if (null1) begin
                    ack1_n = 1'b0;
                end
                if (null0 && null1 && !link.out_ack) begin
                    state_n = S_IDLE;
                end
            end
            // Inputs are deliberately ignored until the consumer catches up.
            S_WAIT: begin
                if (link.out_ack == phase_q) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any token in flight without emitting toggles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= 2'b00;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
            phase_q <= 1'b0;
            prev0_q <= '0;
            prev1_q <= '0;
        end else begin
            state_q <= state_n;
            out_q   <= out_n;
            ack0_q  <= ack0_n;
            ack1_q  <= ack1_n;
            err_q   <= err_n;
            phase_q <= phase_n;
            prev0_q <= prev0_n;
            prev1_q <= prev1_n;
        end
    end

    assign link.out     = out_q;
    assign link.in0_ack = ack0_q;
    assign link.in1_ack = ack1_q;
    assign link.err     = err_q;
endmodule

// File: tb/tb_eqn_dr_hs.sv
// tb_eqn_dr_hs
// Exercises three comparators side by side: FP, FP with INVERT, and TP.
// Expected results come from plain 8-bit values: equality of the operands,
// a running record of which result rail has toggled, and ack parity.
module tb_eqn_dr_hs;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    eqn_dr_hs_if #(.WIDTH(8)) fp_if ();
    eqn_dr_hs_if #(.WIDTH(8)) fpi_if ();
    eqn_dr_hs_if #(.WIDTH(8)) tp_if ();

    eqn_dr_hs #(.WIDTH(8), .ENC("FP"), .INVERT(1'b0)) dut_fp  (.clk(clk), .rst(rst), .link(fp_if));
    eqn_dr_hs #(.WIDTH(8), .ENC("FP"), .INVERT(1'b1)) dut_fpi (.clk(clk), .rst(rst), .link(fpi_if));
    eqn_dr_hs #(.WIDTH(8), .ENC("TP"), .INVERT(1'b0)) dut_tp  (.clk(clk), .rst(rst), .link(tp_if));

    // TP model: levels currently driven, levels of the last accepted token,
    // and the expected output/ack/err state.
    logic [15:0] tp_line0, tp_line1, tp_acc0, tp_acc1;
    logic [1:0]  tp_exp_out;
    logic        tp_exp_ack;
    logic        tp_exp_err;
    logic        fp_exp_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-hot-per-digit dual-rail code of a byte; also the TP toggle mask.
    function automatic logic [15:0] rails(input logic [7:0] v);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive both FP comparators identically.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic e, input logic oa);
        fp_if.in0      = a;
        fp_if.in1      = b;
        fp_if.en       = e;
        fp_if.out_ack  = oa;
        fpi_if.in0     = a;
        fpi_if.in1     = b;
        fpi_if.en      = e;
        fpi_if.out_ack = oa;
    endtask

    task automatic apply_tp();
        tp_if.in0 = tp_line0;
        tp_if.in1 = tp_line1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
        tp_if.en = 1'b0; tp_if.in0 = '0; tp_if.in1 = '0; tp_if.out_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tp_line0 = '0; tp_line1 = '0; tp_acc0 = '0; tp_acc1 = '0;
        tp_exp_out = 2'b00; tp_exp_ack = 1'b0; tp_exp_err = 1'b0; fp_exp_err = 1'b0;
        total++;
        if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_fp: got %b expected 00000",
                     {fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err});
        end
        total++;
        if ({fpi_if.out, fpi_if.in0_ack, fpi_if.in1_ack, fpi_if.err} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_fpi: got %b expected 00000",
                     {fpi_if.out, fpi_if.in0_ack, fpi_if.in1_ack, fpi_if.err});
        end
        total++;
        if ({tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_tp: got %b expected 00000",
                     {tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err});
        end
    endtask

    task automatic test_fp_tokens();
        logic [7:0] av [8];
        logic [7:0] bv [8];
        logic [1:0] exp_out;
        av[0] = 8'hA5; bv[0] = 8'hA5;
        av[1] = 8'h3C; bv[1] = 8'h3D;
        for (int k = 2; k < 8; k++) begin
            av[k] = 8'($urandom);
            bv[k] = ($urandom_range(0, 1) == 1) ? av[k] : 8'($urandom);
        end
        for (int k = 0; k < 8; k++) begin
            exp_out = (av[k] == bv[k]) ? 2'b10 : 2'b01;
            applyStimulus(rails(av[k]), rails(bv[k]), 1'b1, 1'b0);
            tick();
            total++;
            if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err} !== {exp_out, 2'b11, fp_exp_err}) begin
                bad++;
                $display("[TB] FAIL fp_data[%0d]: got %b expected %b", k,
                         {fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err}, {exp_out, 2'b11, fp_exp_err});
            end
            total++;
            if ({fpi_if.out, fpi_if.in0_ack, fpi_if.in1_ack} !== {~exp_out, 2'b11}) begin
                bad++;
                $display("[TB] FAIL fpi_data[%0d]: got %b expected %b", k,
                         {fpi_if.out, fpi_if.in0_ack, fpi_if.in1_ack}, {~exp_out, 2'b11});
            end
            applyStimulus(rails(av[k]), rails(bv[k]), 1'b1, 1'b1);
            tick();
            total++;
            if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack} !== 4'b0011) begin
                bad++;
                $display("[TB] FAIL fp_rtz_out[%0d]: got %b expected 0011", k,
                         {fp_if.out, fp_if.in0_ack, fp_if.in1_ack});
            end
            applyStimulus(16'h0, rails(bv[k]), 1'b1, 1'b1);
            tick();
            total++;
            if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack} !== 4'b0001) begin
                bad++;
                $display("[TB] FAIL fp_rtz_ack0[%0d]: got %b expected 0001", k,
                         {fp_if.out, fp_if.in0_ack, fp_if.in1_ack});
            end
            applyStimulus(16'h0, 16'h0, 1'b1, 1'b1);
            tick();
            applyStimulus(16'h0, 16'h0, 1'b1, 1'b0);
            tick();
            total++;
            if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack} !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL fp_idle[%0d]: got %b expected 0000", k,
                         {fp_if.out, fp_if.in0_ack, fp_if.in1_ack});
            end
        end
    endtask

    task automatic test_fp_skew();
        applyStimulus(rails(8'h5A), 16'h0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack} !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL fp_skew_wait[%0d]: got %b expected 0000", c,
                         {fp_if.out, fp_if.in0_ack, fp_if.in1_ack});
            end
        end
        applyStimulus(rails(8'h5A), rails(8'h5A), 1'b1, 1'b0);
        tick();
        total++;
        if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack} !== 4'b1011) begin
            bad++;
            $display("[TB] FAIL fp_skew_accept: got %b expected 1011",
                     {fp_if.out, fp_if.in0_ack, fp_if.in1_ack});
        end
        applyStimulus(rails(8'h5A), rails(8'h5A), 1'b1, 1'b1);
        tick();
        applyStimulus(16'h0, 16'h0, 1'b1, 1'b1);
        tick();
        applyStimulus(16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        applyStimulus(rails(8'h77), rails(8'h77), 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack} !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL fp_en_low[%0d]: got %b expected 0000", c,
                         {fp_if.out, fp_if.in0_ack, fp_if.in1_ack});
            end
        end
        applyStimulus(16'h0, 16'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_fp_illegal();
        logic [15:0] bad_op;
        bad_op = rails(8'hC3);
        bad_op[7:6] = 2'b11;
        applyStimulus(rails(8'hC3), bad_op, 1'b1, 1'b0);
        fp_exp_err = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err} !== 5'b00001) begin
                bad++;
                $display("[TB] FAIL fp_illegal[%0d]: got %b expected 00001", c,
                         {fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err});
            end
        end
        applyStimulus(rails(8'hC3), rails(8'hC3), 1'b1, 1'b0);
        tick();
        total++;
        if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err} !== 5'b10111) begin
            bad++;
            $display("[TB] FAIL fp_after_illegal: got %b expected 10111",
                     {fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err});
        end
        applyStimulus(rails(8'hC3), rails(8'hC3), 1'b1, 1'b1);
        tick();
        applyStimulus(16'h0, 16'h0, 1'b1, 1'b1);
        tick();
        applyStimulus(16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        total++;
        if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err} !== 5'b00001) begin
            bad++;
            $display("[TB] FAIL fp_err_sticky: got %b expected 00001",
                     {fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err});
        end
    endtask

    task automatic test_tp_stream();
        logic [7:0] av [6];
        logic [7:0] bv [6];
        av[0] = 8'hA5; bv[0] = 8'hA5;
        av[1] = 8'h3C; bv[1] = 8'h3C;
        av[2] = 8'h3C; bv[2] = 8'h3D;
        for (int k = 3; k < 6; k++) begin
            av[k] = 8'($urandom);
            bv[k] = ($urandom_range(0, 1) == 1) ? av[k] : 8'($urandom);
        end
        tp_if.en = 1'b1;
        tp_line0 = tp_acc0 ^ rails(av[0]);
        tp_line1 = tp_acc1 ^ rails(bv[0]);
        apply_tp();
        for (int k = 0; k < 6; k++) begin
            tick();
            tp_exp_out = tp_exp_out ^ ((av[k] == bv[k]) ? 2'b10 : 2'b01);
            tp_exp_ack = ~tp_exp_ack;
            tp_acc0 = tp_line0;
            tp_acc1 = tp_line1;
            total++;
            if ({tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err} !==
                {tp_exp_out, tp_exp_ack, tp_exp_ack, tp_exp_err}) begin
                bad++;
                $display("[TB] FAIL tp_accept[%0d]: got %b expected %b", k,
                         {tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err},
                         {tp_exp_out, tp_exp_ack, tp_exp_ack, tp_exp_err});
            end
            if (k < 5) begin
                tp_line0 = tp_acc0 ^ rails(av[k+1]);
                tp_line1 = tp_acc1 ^ rails(bv[k+1]);
                apply_tp();
            end
            for (int c = 0; c < 2; c++) begin
                tick();
                total++;
                if ({tp_if.out, tp_if.in0_ack, tp_if.in1_ack} !== {tp_exp_out, tp_exp_ack, tp_exp_ack}) begin
                    bad++;
                    $display("[TB] FAIL tp_hold[%0d.%0d]: got %b expected %b", k, c,
                             {tp_if.out, tp_if.in0_ack, tp_if.in1_ack}, {tp_exp_out, tp_exp_ack, tp_exp_ack});
                end
            end
            tp_if.out_ack = tp_exp_ack;
            tick();
            total++;
            if ({tp_if.out, tp_if.in0_ack, tp_if.in1_ack} !== {tp_exp_out, tp_exp_ack, tp_exp_ack}) begin
                bad++;
                $display("[TB] FAIL tp_release[%0d]: got %b expected %b", k,
                         {tp_if.out, tp_if.in0_ack, tp_if.in1_ack}, {tp_exp_out, tp_exp_ack, tp_exp_ack});
            end
        end
    endtask

    task automatic test_tp_illegal();
        logic [15:0] mask;
        mask = rails(8'h96);
        mask[7:6] = 2'b11;
        tp_line0 = tp_acc0 ^ rails(8'h96);
        tp_line1 = tp_acc1 ^ mask;
        apply_tp();
        tp_exp_err = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if ({tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err} !==
                {tp_exp_out, tp_exp_ack, tp_exp_ack, 1'b1}) begin
                bad++;
                $display("[TB] FAIL tp_illegal[%0d]: got %b expected %b", c,
                         {tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err},
                         {tp_exp_out, tp_exp_ack, tp_exp_ack, 1'b1});
            end
        end
        tp_line1 = tp_acc1 ^ rails(8'h96);
        apply_tp();
        tick();
        tp_exp_out = tp_exp_out ^ 2'b10;
        tp_exp_ack = ~tp_exp_ack;
        tp_acc0 = tp_line0;
        tp_acc1 = tp_line1;
        total++;
        if ({tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err} !==
            {tp_exp_out, tp_exp_ack, tp_exp_ack, 1'b1}) begin
            bad++;
            $display("[TB] FAIL tp_after_illegal: got %b expected %b",
                     {tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err},
                     {tp_exp_out, tp_exp_ack, tp_exp_ack, 1'b1});
        end
        tp_if.out_ack = tp_exp_ack;
        tick();
    endtask

    task automatic test_reset_mid();
        applyStimulus(rails(8'h11), rails(8'h11), 1'b1, 1'b0);
        tp_line0 = tp_acc0 ^ rails(8'h22);
        tp_line1 = tp_acc1 ^ rails(8'h23);
        apply_tp();
        tick();
        tp_exp_out = tp_exp_out ^ 2'b01;
        tp_exp_ack = ~tp_exp_ack;
        total++;
        if ({fp_if.out, tp_if.out} !== {2'b10, tp_exp_out}) begin
            bad++;
            $display("[TB] FAIL mid_token: got %b expected %b", {fp_if.out, tp_if.out}, {2'b10, tp_exp_out});
        end
        rst = 1'b1;
        applyStimulus(16'h0, 16'h0, 1'b1, 1'b0);
        tp_if.in0 = '0; tp_if.in1 = '0; tp_if.out_ack = 1'b0;
        tick();
        rst = 1'b0;
        tp_line0 = '0; tp_line1 = '0; tp_acc0 = '0; tp_acc1 = '0;
        tp_exp_out = 2'b00; tp_exp_ack = 1'b0; tp_exp_err = 1'b0; fp_exp_err = 1'b0;
        total++;
        if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err,
             tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err} !== 10'b0) begin
            bad++;
            $display("[TB] FAIL mid_reset: got %b expected 0000000000",
                     {fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err,
                      tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err});
        end
        applyStimulus(rails(8'h7E), rails(8'h81), 1'b1, 1'b0);
        tp_line0 = rails(8'h7E);
        tp_line1 = rails(8'h7E);
        apply_tp();
        tick();
        total++;
        if ({fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err} !== 5'b01110) begin
            bad++;
            $display("[TB] FAIL fresh_fp: got %b expected 01110",
                     {fp_if.out, fp_if.in0_ack, fp_if.in1_ack, fp_if.err});
        end
        total++;
        if ({tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err} !== 5'b10110) begin
            bad++;
            $display("[TB] FAIL fresh_tp: got %b expected 10110",
                     {tp_if.out, tp_if.in0_ack, tp_if.in1_ack, tp_if.err});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fp_tokens();
        test_fp_skew();
        test_fp_illegal();
        test_tp_stream();
        test_tp_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
